// File: rtl/svm_vector_sequencer.sv
// Centre-aligned SVM vector sequencer: turns one (v0,v1,v2,t1,t2,T) set per carrier
// period into a per-cycle vector index stream. Define SVM_5SEG_EN for 5-segment mode.
`timescale 1ns/1ps

// state | meaning
// IDLE  | not running, vec_idx=0, waiting for en with a valid set
// UP    | segments 0..3 of the current period
// DOWN  | segments 4..7 of the current period
module svm_vector_sequencer #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [CNT_W-1:0] half_per,
  input  logic [CNT_W-1:0] t1,
  input  logic [CNT_W-1:0] t2,
  input  logic [7:0]       v0,
  input  logic [7:0]       v1,
  input  logic [7:0]       v2,
  output logic [7:0]       vec_idx,
  output logic [2:0]       seg,
  output logic             period_start,
  output logic             clip
);

  typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2} state_t;

  typedef struct packed {
    logic [CNT_W-1:0] za;
    logic [CNT_W-1:0] d1;
    logic [CNT_W-1:0] d2;
    logic [CNT_W-1:0] zb;
    logic [7:0]       x0;
    logic [7:0]       x1;
    logic [7:0]       x2;
    logic             clp;
  } set_t;

  function automatic set_t derive(input logic [CNT_W-1:0] hp, input logic [CNT_W-1:0] a,
                                  input logic [CNT_W-1:0] b, input logic [7:0] x0,
                                  input logic [7:0] x1, input logic [7:0] x2);
    set_t             s;
    logic [CNT_W-1:0] tp;
    logic [CNT_W-1:0] t0;
    logic [CNT_W:0]   sum;
    tp   = (hp == '0) ? CNT_W'(1) : hp;
    sum  = {1'b0, a} + {1'b0, b};
    s.x0 = x0;
    s.x1 = x1;
    s.x2 = x2;
    if (a > tp) begin
      s.d1  = tp;
      s.d2  = '0;
      s.clp = 1'b1;
    end else if (sum > {1'b0, tp}) begin
      s.d1  = a;
      s.d2  = tp - a;
      s.clp = 1'b1;
    end else begin
      s.d1  = a;
      s.d2  = b;
      s.clp = 1'b0;
    end
    t0 = tp - s.d1 - s.d2;
`ifdef SVM_5SEG_EN
    // whole zero time sits at the period edges; segments 3 and 4 collapse
    s.za = t0;
    s.zb = '0;
`else
    s.za = t0 >> 1;
    s.zb = t0 - (t0 >> 1);
`endif
    return s;
  endfunction

  function automatic logic [CNT_W-1:0] seg_dur(input set_t s, input logic [2:0] n);
    case (n)
      3'd0, 3'd7: seg_dur = s.za;
      3'd1, 3'd6: seg_dur = s.d1;
      3'd2, 3'd5: seg_dur = s.d2;
      default:    seg_dur = s.zb;
    endcase
  endfunction

  function automatic logic [7:0] seg_vec(input set_t s, input logic [2:0] n);
    case (n)
      3'd1, 3'd6: seg_vec = s.x1;
      3'd2, 3'd5: seg_vec = s.x2;
      default:    seg_vec = s.x0;
    endcase
  endfunction

  logic             sh_full;
  logic [CNT_W-1:0] sh_hp, sh_t1, sh_t2;
  logic [7:0]       sh_v0, sh_v1, sh_v2;
  set_t             act;
  logic             act_valid;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] timer, timer_nxt;
  logic [2:0]       seg_nxt;
  logic             start, copy;
  logic             nxt_found;
  logic [2:0]       nxt_seg, first_seg;
  set_t             sh_set, new_set, out_set;
  logic [7:0]       vec_nxt;
  logic [2:0]       seg_o_nxt;
  logic             clip_nxt;

  assign load_ready = ~sh_full;
  assign sh_set     = derive(sh_hp, sh_t1, sh_t2, sh_v0, sh_v1, sh_v2);
  assign new_set    = sh_full ? sh_set : act;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_full   <= 1'b0;
      sh_hp     <= '0;
      sh_t1     <= '0;
      sh_t2     <= '0;
      sh_v0     <= '0;
      sh_v1     <= '0;
      sh_v2     <= '0;
      act       <= '0;
      act_valid <= 1'b0;
    end else if (copy) begin
      act       <= sh_set;
      act_valid <= 1'b1;
      sh_full   <= 1'b0;
    end else if (load_valid && !sh_full) begin
      sh_hp   <= half_per;
      sh_t1   <= t1;
      sh_t2   <= t2;
      sh_v0   <= v0;
      sh_v1   <= v1;
      sh_v2   <= v2;
      sh_full <= 1'b1;
    end
  end

  // lowest non-empty segment after the current one, and first one of the next period
  always_comb begin
    nxt_found = 1'b0;
    nxt_seg   = 3'd0;
    first_seg = 3'd0;
    for (int s = 7; s >= 0; s--) begin
      if (3'(s) > seg && seg_dur(act, 3'(s)) != '0) begin
        nxt_found = 1'b1;
        nxt_seg   = 3'(s);
      end
    end
    for (int s = 3; s >= 0; s--) begin
      if (seg_dur(new_set, 3'(s)) != '0) first_seg = 3'(s);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      timer        <= '0;
      seg          <= 3'd0;
      vec_idx      <= 8'd0;
      period_start <= 1'b0;
      clip         <= 1'b0;
    end else begin
      state        <= state_nxt;
      timer        <= timer_nxt;
      seg          <= seg_o_nxt;
      vec_idx      <= vec_nxt;
      period_start <= start;
      clip         <= clip_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    seg_nxt   = seg;
    timer_nxt = timer;
    start     = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
      seg_nxt   = 3'd0;
      timer_nxt = '0;
    end else begin
      case (state)
        IDLE: start = sh_full || act_valid;
        UP, DOWN: begin
          if (timer != '0) begin
            timer_nxt = timer - CNT_W'(1);
          end else if (nxt_found) begin
            seg_nxt   = nxt_seg;
            timer_nxt = seg_dur(act, nxt_seg) - CNT_W'(1);
            state_nxt = nxt_seg[2] ? DOWN : UP;
          end else begin
            start = 1'b1;
          end
        end
        default: state_nxt = IDLE;
      endcase
      if (start) begin
        seg_nxt   = first_seg;
        timer_nxt = seg_dur(new_set, first_seg) - CNT_W'(1);
        state_nxt = UP;
      end
    end
  end

  always_comb begin
    copy      = start && sh_full;
    out_set   = start ? new_set : act;
    vec_nxt   = 8'd0;
    seg_o_nxt = 3'd0;
    clip_nxt  = 1'b0;
    if (state_nxt != IDLE) begin
      vec_nxt   = seg_vec(out_set, seg_nxt);
      seg_o_nxt = seg_nxt;
      clip_nxt  = out_set.clp;
    end
  end

endmodule

// File: tb/tb_svm_vector_sequencer.sv
// Bench for svm_vector_sequencer: directed scenarios plus random sets, checked each
// cycle against a queue-based period expansion model.
`timescale 1ns/1ps

module tb_svm_vector_sequencer;

  logic        clk, rst_n, en, load_valid, load_ready;
  logic [15:0] half_per, t1, t2;
  logic [7:0]  v0, v1, v2, vec_idx;
  logic [2:0]  seg;
  logic        period_start, clip;

  svm_vector_sequencer dut (
    .clk(clk), .rst_n(rst_n), .en(en), .load_valid(load_valid), .load_ready(load_ready),
    .half_per(half_per), .t1(t1), .t2(t2), .v0(v0), .v1(v1), .v2(v2),
    .vec_idx(vec_idx), .seg(seg), .period_start(period_start), .clip(clip)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] vec;
    logic [2:0] sg;
    logic       ps;
    logic       cl;
  } exp_t;

  typedef struct {
    int         hp, a, b;
    logic [7:0] x0, x1, x2;
  } mset_t;

  int    passed = 0;
  int    fails  = 0;
  exp_t  m_q[$];
  mset_t m_sh, m_act;
  bit    m_sh_full, m_act_valid;

  logic [7:0] rec_vec  [1:80];
  logic [2:0] rec_seg  [1:80];
  logic       rec_ps   [1:80];
  logic       rec_lr   [1:80];
  logic       rec_clip [1:80];

`ifdef SVM_5SEG_EN
  logic [7:0] nom_exp [20] = '{19,19,19,1,1,1,3,3,3,3,3,3,3,3,1,1,1,19,19,19};
`else
  logic [7:0] nom_exp [20] = '{19,1,1,1,3,3,3,3,19,19,19,19,3,3,3,3,1,1,1,19};
`endif
  logic [7:0] clip_exp [16] = '{1,1,1,1,1,3,3,3,3,3,3,1,1,1,1,1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // one period = T cycles up then T cycles down, built from the dwell rules
  task automatic expand(input mset_t s);
    int   tp, a, b, t0, zlo, zhi;
    bit   c, first;
    int   lens [8];
    logic [7:0] vecs [8];
    exp_t e;
    tp = (s.hp == 0) ? 1 : s.hp;
    a  = s.a;
    b  = s.b;
    c  = 1'b0;
    if (a > tp) begin
      a = tp; b = 0; c = 1'b1;
    end else if (a + b > tp) begin
      b = tp - a; c = 1'b1;
    end
    t0 = tp - a - b;
`ifdef SVM_5SEG_EN
    zlo = t0; zhi = 0;
`else
    zlo = t0 / 2; zhi = t0 - zlo;
`endif
    lens[0] = zlo; lens[1] = a; lens[2] = b; lens[3] = zhi;
    lens[4] = zhi; lens[5] = b; lens[6] = a; lens[7] = zlo;
    vecs[0] = s.x0; vecs[1] = s.x1; vecs[2] = s.x2; vecs[3] = s.x0;
    vecs[4] = s.x0; vecs[5] = s.x2; vecs[6] = s.x1; vecs[7] = s.x0;
    first = 1'b1;
    for (int k = 0; k < 8; k++) begin
      for (int n = 0; n < lens[k]; n++) begin
        e.vec = vecs[k]; e.sg = 3'(k); e.ps = first; e.cl = c;
        m_q.push_back(e);
        first = 1'b0;
      end
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_sh_full   = 1'b0;
    m_act_valid = 1'b0;
  endtask

  task automatic model_edge();
    bit ready_old;
    ready_old = !m_sh_full;
    if (!en) begin
      m_q.delete();
    end else begin
      if (m_q.size() > 0) void'(m_q.pop_front());
      if (m_q.size() == 0) begin
        if (m_sh_full) begin
          m_act = m_sh; m_act_valid = 1'b1; m_sh_full = 1'b0;
        end
        if (m_act_valid) expand(m_act);
      end
    end
    if (load_valid && ready_old) begin
      m_sh.hp = int'(half_per); m_sh.a = int'(t1); m_sh.b = int'(t2);
      m_sh.x0 = v0; m_sh.x1 = v1; m_sh.x2 = v2;
      m_sh_full = 1'b1;
    end
  endtask

  task automatic check_outputs();
    exp_t e;
    if (m_q.size() > 0) e = m_q[0];
    else begin
      e.vec = 8'd0; e.sg = 3'd0; e.ps = 1'b0; e.cl = 1'b0;
    end
    chk("vec_idx", 32'(vec_idx), 32'(e.vec));
    chk("seg", 32'(seg), 32'(e.sg));
    chk("period_start", 32'(period_start), 32'(e.ps));
    chk("clip", 32'(clip), 32'(e.cl));
    chk("load_ready", 32'(load_ready), 32'(!m_sh_full));
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_outputs();
  endtask

  task automatic set_in(input int hp, input int a, input int b,
                        input int x0, input int x1, input int x2);
    half_per = 16'(hp); t1 = 16'(a); t2 = 16'(b);
    v0 = 8'(x0); v1 = 8'(x1); v2 = 8'(x2);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; load_valid = 1'b0;
    set_in(0, 0, 0, 0, 0, 0);
    model_reset();
    #3;
    chk("rst_vec", 32'(vec_idx), 0);
    chk("rst_lr", 32'(load_ready), 1);
    check_outputs();
    #9 rst_n = 1'b1;

    // set A accepted while disabled, then enabled
    set_in(10, 3, 4, 19, 1, 3);
    load_valid = 1'b1;
    step();
    load_valid = 1'b0;
    en = 1'b1;
    step();

    for (int i = 1; i <= 80; i++) begin
      rec_vec[i] = vec_idx; rec_seg[i] = seg; rec_ps[i] = period_start;
      rec_lr[i] = load_ready; rec_clip[i] = clip;
      case (i)
        4:  begin set_in(8, 5, 6, 19, 1, 3); load_valid = 1'b1; end
        5:  begin set_in(8, 9, 0, 19, 1, 3); load_valid = 1'b1; end
        22: load_valid = 1'b0;
        40: begin set_in(10, 3, 4, 19, 1, 3); load_valid = 1'b1; end
        41: load_valid = 1'b0;
        66: en = 1'b0;
        68: en = 1'b1;
        default: ;
      endcase
      step();
    end

    for (int i = 0; i < 20; i++) chk($sformatf("nominal[%0d]", i), 32'(rec_vec[i+1]), 32'(nom_exp[i]));
    for (int i = 0; i < 16; i++) chk($sformatf("clipped[%0d]", i), 32'(rec_vec[i+21]), 32'(clip_exp[i]));
    for (int i = 37; i <= 52; i++) chk($sformatf("t1_over_T[%0d]", i), 32'(rec_vec[i]), 1);
    chk("ps_first", 32'(rec_ps[1]), 1);
    chk("ps_second_cycle", 32'(rec_ps[2]), 0);
    chk("ps_boundary", 32'(rec_ps[21]), 1);
    chk("clip_nominal", 32'(rec_clip[1]), 0);
    chk("clip_clipped", 32'(rec_clip[21]), 1);
    chk("clip_t1_over", 32'(rec_clip[37]), 1);
    chk("lr_before_boundary", 32'(rec_lr[20]), 0);
    chk("lr_after_boundary", 32'(rec_lr[21]), 1);
    chk("lr_third_taken", 32'(rec_lr[22]), 0);
    chk("reload_ps", 32'(rec_ps[53]), 1);
    chk("reload_vec", 32'(rec_vec[53]), 19);
    chk("en_drop_vec", 32'(rec_vec[67]), 0);
    chk("en_drop_seg", 32'(rec_seg[67]), 0);
    chk("en_drop_clip", 32'(rec_clip[67]), 0);
    chk("en_low_vec", 32'(rec_vec[68]), 0);
    chk("restart_ps", 32'(rec_ps[69]), 1);
    chk("restart_seg", 32'(rec_seg[69]), 0);
    chk("restart_vec", 32'(rec_vec[69]), 19);

    // asynchronous reset in the middle of a running period
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    chk("async_rst_vec", 32'(vec_idx), 0);
    chk("async_rst_lr", 32'(load_ready), 1);
    check_outputs();
    #2 rst_n = 1'b1;
    en = 1'b1; load_valid = 1'b0;
    repeat (10) step();
    chk("no_reload_idle", 32'(vec_idx), 0);

    repeat (3000) begin
      en         = ($urandom_range(0, 49) != 0);
      load_valid = ($urandom_range(0, 3) == 0);
      set_in($urandom_range(0, 24), $urandom_range(0, 30), $urandom_range(0, 30),
             19 + $urandom_range(0, 2), $urandom_range(1, 27), $urandom_range(1, 27));
      if ($urandom_range(0, 15) == 0) t1 = 16'hFFF0 + 16'($urandom_range(0, 15));
      if ($urandom_range(0, 15) == 0) t2 = 16'hFFF0 + 16'($urandom_range(0, 15));
      step();
    end

    $display("%0d/%0d checks passed", passed, passed + fails);
    $finish;
  end

endmodule

// File: doc/svm_vector_sequencer.md
Name: svm_vector_sequencer

Overview:
- Upstream stage of the SVM switch-pattern decoder.
- Accepts one modulation set per carrier period: three vector indices (v0 zero, v1, v2 active) and dwell times t1, t2.
- Emits a registered 8-bit vector index each clock as a symmetric centre-aligned sequence; the decoder maps each index to the 18-bit gate pattern.
- Index 0 is emitted whenever idle, so the decoder drives all gates off.

Parameters:
- CNT_W, 16, width of half-period and dwell-time fields and of the segment timer.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- en  in  1  run enable; sampled every cycle
- load_valid  in  1  parameter set offered
- load_ready  out  1  shadow register empty; set accepted when load_valid&&load_ready
- half_per  in  CNT_W  carrier half-period T in cycles
- t1  in  CNT_W  dwell of v1 per half-period
- t2  in  CNT_W  dwell of v2 per half-period
- v0  in  8  zero-vector index (decoder code 19/20/21)
- v1  in  8  first active vector index (1..27)
- v2  in  8  second active vector index (1..27)
- vec_idx  out  8  registered vector index to decoder
- seg  out  3  current segment number 0..7 (0 when idle)
- period_start  out  1  one-cycle pulse on first output cycle of each period
- clip  out  1  dwell times of active period were saturated

Behaviour:
- Reset (async, rst_n=0): vec_idx=0, seg=0, period_start=0, clip=0, load_ready=1, shadow empty, active set invalid, state IDLE.
- Buffering: one shadow register.
  - load_ready = shadow empty (registered).
  - Handshake fills shadow; load_ready drops the next cycle.
  - Shadow copies to active only at a period boundary; load_ready rises the cycle after the copy.
- States: IDLE, UP, DOWN.
- IDLE exit: if en=1 and shadow full in cycle N, copy to active in N. In N+1, first non-zero segment appears on vec_idx with period_start=1.
- IDLE hold: if en=1 but no set was ever loaded, stay IDLE and output 0.
- Durations computed at copy:
  - T = max(half_per, 1).
  - If t1 > T: t1' = T, t2' = 0, clip = 1.
  - Else if t1+t2 > T: t2' = T−t1, clip = 1.
  - Otherwise t1' = t1, t2' = t2, clip = 0.
  - t0 = T−t1'−t2'; za = floor(t0/2); zb = t0−za.
  - clip holds for the whole period.
- UP segments 0..3: v0 za, v1 t1', v2 t2', v0 zb.
- DOWN segments 4..7: v0 zb, v2 t2', v1 t1', v0 za.
- Each segment drives vec_idx for exactly its duration in cycles. Zero-length segments are skipped with no bubble cycle. Period = 2T cycles exactly.
- Period boundary, last cycle of segment 7:
  - en=1: copy shadow if full, otherwise reuse the active set. Next cycle starts segment 0 with period_start=1. No gap cycle.
  - en=0: see below.
- en=0 in any cycle: next cycle state IDLE, vec_idx=0, seg=0, clip=0. The active set is retained and the shadow is unchanged. Re-enable restarts at segment 0, using the shadow if full, else the retained active set.
- Timer: CNT_W-bit down-counter; no wrap, since all durations are ≤ T.

Optional Feature:
- Macro SVM_5SEG_EN.
- Defined: discontinuous 5-segment mode.
  - UP = v0 t0, v1 t1', v2 t2'.
  - DOWN = v2 t2', v1 t1', v0 t0.
  - v2 runs 2·t2' contiguous. seg numbering is unchanged; segments 3 and 4 always have zero length and are skipped.
- Undefined: 7-segment symmetric sequence as above.

Test Plan:
- Nominal: T=10, t1=3, t2=4, v0=19, v1=1, v2=3, en=1 → vec_idx = 19×1, 1×3, 3×4, 19×2, 19×2 (4 cycles of 19), 3×4, 1×3, 19×1; 20 cycles; period_start on cycle 1 and cycle 21; clip=0.
- Clipping: T=8, t1=5, t2=6 → clip=1, sequence 1×5, 3×3, 3×3, 1×5, no 19; T=8, t1=9 → 1×16 only.
- Shadow: load set A, start, load set B mid-period → load_ready=0 until the cycle after the boundary; B output begins exactly at cycle 2T+1 with no gap; a third load during the period is stalled.
- Enable drop: en=0 mid-segment 5 → next cycle vec_idx=0, seg=0; en=1 again → restarts segment 0 with period_start=1.
- Reset mid-period: rst_n low asynchronously → vec_idx=0, load_ready=1 immediately; with en=1 and no reload, output remains 0.
- SVM_5SEG_EN defined, T=10, t1=3, t2=4 → 19×3, 1×3, 3×8, 1×3, 19×3.
